// File: rtl/local_port_input_vc_buffer_if.sv
// Bundle of local-port flit input, per-VC head/dequeue, and credit-return signals.
// master: upstream injector plus switch allocator; slave: the VC buffer.
interface local_port_input_vc_buffer_if #(
  parameter int VC_NUM          = 2,
  parameter int VC_DEPTH        = 2,
  parameter int FLIT_W          = 64,
  parameter int ROUTE_W         = 3,
  parameter int VC_ID_NUM_MAX_W = 2,
  parameter int VC_DEPTH_W      = $clog2(VC_DEPTH + 1)
);
  logic                                 flit_v_i;
  logic [VC_ID_NUM_MAX_W-1:0]           flit_vc_id_i;
  logic [FLIT_W-1:0]                    flit_data_i;
  logic [ROUTE_W-1:0]                   flit_look_ahead_routing_i;
  logic [VC_NUM-1:0]                    head_vld_o;
  logic [VC_NUM-1:0][FLIT_W-1:0]        head_data_o;
  logic [VC_NUM-1:0][ROUTE_W-1:0]       head_look_ahead_routing_o;
  logic [VC_NUM-1:0]                    deq_i;
  logic                                 tx_lcrd_v_o;
  logic [VC_ID_NUM_MAX_W-1:0]           tx_lcrd_id_o;
  logic [VC_NUM-1:0][VC_DEPTH_W-1:0]    vc_occupancy_o;
  logic                                 proto_err_o;

  modport master (
    output flit_v_i, flit_vc_id_i, flit_data_i, flit_look_ahead_routing_i, deq_i,
    input  head_vld_o, head_data_o, head_look_ahead_routing_o,
    input  tx_lcrd_v_o, tx_lcrd_id_o, vc_occupancy_o, proto_err_o
  );

  modport slave (
    input  flit_v_i, flit_vc_id_i, flit_data_i, flit_look_ahead_routing_i, deq_i,
    output head_vld_o, head_data_o, head_look_ahead_routing_o,
    output tx_lcrd_v_o, tx_lcrd_id_o, vc_occupancy_o, proto_err_o
  );
endinterface

// File: rtl/local_port_input_vc_buffer.sv
// Local injection port input buffer: per-VC circular FIFOs with credit return upstream.
// Define LOCAL_VC_BUF_CREDIT_REG_EN to register the credit return by one cycle.
module local_port_input_vc_buffer #(
  parameter int VC_NUM          = 2,
  parameter int VC_DEPTH        = 2,
  parameter int FLIT_W          = 64,
  parameter int ROUTE_W         = 3,
  parameter int VC_ID_NUM_MAX_W = 2,
  parameter int VC_DEPTH_W      = $clog2(VC_DEPTH + 1)
) (
  input logic                          clk,
  input logic                          rstn,
  local_port_input_vc_buffer_if.slave  bus
);
  localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int ENT_W = FLIT_W + ROUTE_W;

  logic [ENT_W-1:0]      mem    [VC_NUM][VC_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [VC_NUM];
  logic [PTR_W-1:0]      rd_ptr [VC_NUM];
  logic [VC_DEPTH_W-1:0] occ    [VC_NUM];
  logic                  proto_err;

  logic [VC_NUM-1:0]     vc_vld, vc_full, enq_sel, enq_hit, deq_hit, deq_go;
  logic                  id_ok, enq_full, enq_err, deq_multi, deq_empty, deq_ok, err_now;
  logic [VC_ID_NUM_MAX_W-1:0] deq_idx;

  logic [VC_NUM-1:0][FLIT_W-1:0]     head_data;
  logic [VC_NUM-1:0][ROUTE_W-1:0]    head_route;
  logic [VC_NUM-1:0][VC_DEPTH_W-1:0] occ_flat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    vc_vld  = '0;
    vc_full = '0;
    enq_sel = '0;
    deq_idx = '0;
    id_ok   = int'(bus.flit_vc_id_i) < VC_NUM;
    for (int v = 0; v < VC_NUM; v++) begin
      vc_vld[v]  = occ[v] != '0;
      vc_full[v] = occ[v] == VC_DEPTH_W'(VC_DEPTH);
      enq_sel[v] = int'(bus.flit_vc_id_i) == v;
    end
    // Lowest set request bit wins; anything above it is a protocol error.
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (bus.deq_i[v]) deq_idx = VC_ID_NUM_MAX_W'(v);
    end
    deq_hit   = bus.deq_i & (~bus.deq_i + 1'b1);
    deq_go    = deq_hit & vc_vld;
    deq_multi = (bus.deq_i & ~deq_hit) != '0;
    deq_ok    = deq_go != '0;
    deq_empty = (deq_hit & ~vc_vld) != '0;
    // Full is judged on pre-edge occupancy, so a same-cycle dequeue does not make room.
    enq_full  = (enq_sel & vc_full) != '0;
    enq_hit   = (bus.flit_v_i && id_ok && !enq_full) ? enq_sel : '0;
    enq_err   = bus.flit_v_i && (!id_ok || enq_full);
    err_now   = enq_err || deq_multi || deq_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        occ[v]    <= '0;
      end
      proto_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (enq_hit[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (deq_go[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        case ({enq_hit[v], deq_go[v]})
          2'b10:   occ[v] <= occ[v] + 1'b1;
          2'b01:   occ[v] <= occ[v] - 1'b1;
          default: occ[v] <= occ[v];
        endcase
      end
      if (err_now) proto_err <= 1'b1;
    end
  end

  // Payload storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (enq_hit[v]) mem[v][wr_ptr[v]] <= {bus.flit_data_i, bus.flit_look_ahead_routing_i};
    end
  end

  always_comb begin
    head_data  = '0;
    head_route = '0;
    occ_flat   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      head_data[v]  = mem[v][rd_ptr[v]][ENT_W-1:ROUTE_W];
      head_route[v] = mem[v][rd_ptr[v]][ROUTE_W-1:0];
      occ_flat[v]   = occ[v];
    end
  end

  assign bus.head_vld_o                = vc_vld;
  assign bus.head_data_o               = head_data;
  assign bus.head_look_ahead_routing_o = head_route;
  assign bus.vc_occupancy_o            = occ_flat;
  assign bus.proto_err_o               = proto_err;

`ifdef LOCAL_VC_BUF_CREDIT_REG_EN
  logic                       tx_v_p1;
  logic [VC_ID_NUM_MAX_W-1:0] tx_id_p1;

  // Credit stage: a reset between dequeue and this register drops the credit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_v_p1  <= 1'b0;
      tx_id_p1 <= '0;
    end else begin
      tx_v_p1  <= deq_ok;
      tx_id_p1 <= deq_ok ? deq_idx : '0;
    end
  end

  assign bus.tx_lcrd_v_o  = tx_v_p1;
  assign bus.tx_lcrd_id_o = tx_id_p1;
`else
  assign bus.tx_lcrd_v_o  = deq_ok;
  assign bus.tx_lcrd_id_o = deq_ok ? deq_idx : '0;
`endif
endmodule

// File: tb/tb_local_port_input_vc_buffer.sv
// Bench for local_port_input_vc_buffer: directed vector table, corner sequences, random vs queue model.
module tb_local_port_input_vc_buffer;
  localparam int VC_NUM     = 2;
  localparam int VC_DEPTH   = 2;
  localparam int FLIT_W     = 64;
  localparam int ROUTE_W    = 3;
  localparam int VC_ID_W    = 2;
  localparam int VC_DEPTH_W = $clog2(VC_DEPTH + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  local_port_input_vc_buffer_if #(
    .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .FLIT_W(FLIT_W), .ROUTE_W(ROUTE_W),
    .VC_ID_NUM_MAX_W(VC_ID_W), .VC_DEPTH_W(VC_DEPTH_W)
  ) bus ();

  local_port_input_vc_buffer #(
    .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .FLIT_W(FLIT_W), .ROUTE_W(ROUTE_W),
    .VC_ID_NUM_MAX_W(VC_ID_W), .VC_DEPTH_W(VC_DEPTH_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic               v;
    logic [VC_ID_W-1:0] id;
    logic [63:0]        d;
    logic [2:0]         r;
    logic [1:0]         dq;
    logic [1:0]         e_vld;
    logic [1:0]         e_occ0;
    logic [1:0]         e_occ1;
    logic [63:0]        e_h0;
    logic [63:0]        e_h1;
    logic               e_cv;
    logic [1:0]         e_cid;
    logic               e_err;
  } vec_t;

  // Reference model: one queue of {route, data} per VC plus the sticky error flag.
  logic [ROUTE_W+FLIT_W-1:0] mq [VC_NUM][$];
  bit m_err;
  bit pend_v;
  int pend_id;
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input bit cv, input int cid);
    for (int v = 0; v < VC_NUM; v++) begin
      chk($sformatf("head_vld[%0d]", v), 64'(bus.head_vld_o[v]), 64'(mq[v].size() != 0));
      chk($sformatf("occupancy[%0d]", v), 64'(bus.vc_occupancy_o[v]), 64'(mq[v].size()));
      if (mq[v].size() != 0) begin
        chk($sformatf("head_data[%0d]", v), bus.head_data_o[v], mq[v][0][FLIT_W-1:0]);
        chk($sformatf("head_route[%0d]", v), 64'(bus.head_look_ahead_routing_o[v]),
            64'(mq[v][0][FLIT_W +: ROUTE_W]));
      end
    end
    chk("proto_err", 64'(bus.proto_err_o), 64'(m_err));
    chk("credit_v", 64'(bus.tx_lcrd_v_o), 64'(cv));
    chk("credit_id", 64'(bus.tx_lcrd_id_o), 64'(cid));
  endtask

  task automatic drive_idle();
    bus.flit_v_i = 1'b0;
    bus.flit_vc_id_i = '0;
    bus.flit_data_i = '0;
    bus.flit_look_ahead_routing_i = '0;
    bus.deq_i = '0;
  endtask

  task automatic clear_model();
    for (int v = 0; v < VC_NUM; v++) mq[v].delete();
    m_err = 1'b0;
    pend_v = 1'b0;
    pend_id = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_model();
    rstn = 1'b1;
  endtask

  // One clock: drive, predict from the pre-edge model, check at negedge, commit at posedge.
  task automatic cycle(input logic v, input logic [VC_ID_W-1:0] id, input logic [63:0] d,
                       input logic [2:0] r, input logic [1:0] dq, input bit use_tbl, input vec_t t);
    bit cv;
    int cid;
    int h;
    int idx;
    bit nerr;
    bit do_enq;
    bus.flit_v_i = v;
    bus.flit_vc_id_i = id;
    bus.flit_data_i = d;
    bus.flit_look_ahead_routing_i = r;
    bus.deq_i = dq;
    cv = 1'b0; cid = 0; h = -1; nerr = m_err; do_enq = 1'b0; idx = int'(id);
    for (int i = VC_NUM - 1; i >= 0; i--) if (dq[i]) h = i;
    if (h >= 0) begin
      if ((dq & (dq - 2'd1)) != 2'd0) nerr = 1'b1;
      if (mq[h].size() == 0) nerr = 1'b1;
      else begin cv = 1'b1; cid = h; end
    end
    if (v) begin
      if (idx >= VC_NUM) nerr = 1'b1;
      else if (mq[idx].size() == VC_DEPTH) nerr = 1'b1;
      else do_enq = 1'b1;
    end
    @(negedge clk);
`ifdef LOCAL_VC_BUF_CREDIT_REG_EN
    chk_all(pend_v, pend_id);
`else
    chk_all(cv, cid);
`endif
    if (use_tbl) begin
      chk("tbl head_vld", 64'(bus.head_vld_o), 64'(t.e_vld));
      chk("tbl occ0", 64'(bus.vc_occupancy_o[0]), 64'(t.e_occ0));
      chk("tbl occ1", 64'(bus.vc_occupancy_o[1]), 64'(t.e_occ1));
      if (t.e_vld[0]) chk("tbl head0", bus.head_data_o[0], t.e_h0);
      if (t.e_vld[1]) chk("tbl head1", bus.head_data_o[1], t.e_h1);
      chk("tbl credit_v", 64'(bus.tx_lcrd_v_o), 64'(t.e_cv));
      chk("tbl credit_id", 64'(bus.tx_lcrd_id_o), 64'(t.e_cid));
      chk("tbl proto_err", 64'(bus.proto_err_o), 64'(t.e_err));
    end
    @(posedge clk);
    if (cv) void'(mq[cid].pop_front());
    if (do_enq) mq[idx].push_back({r, d});
    m_err = nerr;
    pend_v = cv;
    pend_id = cid;
    #1;
    drive_idle();
  endtask

  task automatic idle_cycle();
    vec_t none;
    none = '{default: '0};
    cycle(1'b0, '0, 64'd0, 3'd0, 2'b00, 1'b0, none);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[11];
    vec_t t;
    vec_t none;
    none = '{default: '0};
    //         v  id  d      r  dq    vld   o0 o1 h0     h1     cv cid err
    tbl[0]  = '{1, 1, 64'hA, 1, 2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 0, 0, 0};
    tbl[1]  = '{1, 1, 64'hB, 2, 2'b00, 2'b10, 0, 1, 64'h0, 64'hA, 0, 0, 0};
    tbl[2]  = '{0, 0, 64'h0, 0, 2'b10, 2'b10, 0, 2, 64'h0, 64'hA, 1, 1, 0};
    tbl[3]  = '{0, 0, 64'h0, 0, 2'b00, 2'b10, 0, 1, 64'h0, 64'hB, 0, 0, 0};
    tbl[4]  = '{0, 0, 64'h0, 0, 2'b10, 2'b10, 0, 1, 64'h0, 64'hB, 1, 1, 0};
    tbl[5]  = '{1, 0, 64'h1, 3, 2'b00, 2'b00, 0, 0, 64'h0, 64'h0, 0, 0, 0};
    tbl[6]  = '{1, 0, 64'h2, 4, 2'b01, 2'b01, 1, 0, 64'h1, 64'h0, 1, 0, 0};
    tbl[7]  = '{0, 0, 64'h0, 0, 2'b00, 2'b01, 1, 0, 64'h2, 64'h0, 0, 0, 0};
    tbl[8]  = '{1, 0, 64'h3, 5, 2'b00, 2'b01, 1, 0, 64'h2, 64'h0, 0, 0, 0};
    tbl[9]  = '{1, 0, 64'h4, 6, 2'b01, 2'b01, 2, 0, 64'h2, 64'h0, 1, 0, 0};
    tbl[10] = '{0, 0, 64'h0, 0, 2'b00, 2'b01, 1, 0, 64'h3, 64'h0, 0, 0, 1};

    clear_model();
    do_reset();
    @(negedge clk);
    chk_all(1'b0, 0);
    @(posedge clk);
    #1;

    // Directed table: fill/drain VC1, single-entry enq+deq on VC0, full-VC overflow.
    for (int i = 0; i < 11; i++) begin
      t = tbl[i];
`ifdef LOCAL_VC_BUF_CREDIT_REG_EN
      t.e_cv  = (i == 0) ? 1'b0 : tbl[i-1].e_cv;
      t.e_cid = (i == 0) ? 2'd0 : tbl[i-1].e_cid;
`endif
      cycle(t.v, t.id, t.d, t.r, t.dq, 1'b1, t);
    end

    // Multi-hot request with the lowest VC empty: no credit, VC1 untouched, error raised.
    do_reset();
    cycle(1'b1, 2'd1, 64'h55, 3'd7, 2'b00, 1'b0, none);
    cycle(1'b0, 2'd0, 64'h0, 3'd0, 2'b11, 1'b0, none);
    chk("multihot proto_err", 64'(bus.proto_err_o), 64'd1);
    chk("multihot occ1", 64'(bus.vc_occupancy_o[1]), 64'd1);
    chk("multihot head1", bus.head_data_o[1], 64'h55);
    idle_cycle();

    // Out-of-range VC id is dropped and flagged.
    do_reset();
    cycle(1'b1, 2'd2, 64'h77, 3'd1, 2'b00, 1'b0, none);
    chk("bad id proto_err", 64'(bus.proto_err_o), 64'd1);
    chk("bad id head_vld", 64'(bus.head_vld_o), 64'd0);
    idle_cycle();

    // Asynchronous reset mid-traffic empties the FIFOs without waiting for a clock.
    do_reset();
    cycle(1'b1, 2'd0, 64'h10, 3'd1, 2'b00, 1'b0, none);
    cycle(1'b1, 2'd1, 64'h20, 3'd2, 2'b00, 1'b0, none);
    #1;
    rstn = 1'b0;
    #1;
    chk("async rst head_vld", 64'(bus.head_vld_o), 64'd0);
    chk("async rst occ0", 64'(bus.vc_occupancy_o[0]), 64'd0);
    chk("async rst occ1", 64'(bus.vc_occupancy_o[1]), 64'd0);
    do_reset();

`ifdef LOCAL_VC_BUF_CREDIT_REG_EN
    // Registered credit shows one cycle late and is dropped by a reset before it is consumed.
    cycle(1'b1, 2'd1, 64'h99, 3'd3, 2'b00, 1'b0, none);
    cycle(1'b0, 2'd0, 64'h0, 3'd0, 2'b10, 1'b0, none);
    chk("reg credit_v", 64'(bus.tx_lcrd_v_o), 64'd1);
    chk("reg credit_id", 64'(bus.tx_lcrd_id_o), 64'd1);
    rstn = 1'b0;
    #1;
    chk("reg credit dropped", 64'(bus.tx_lcrd_v_o), 64'd0);
    do_reset();
`endif

    // Random traffic in bursts, each starting from reset.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int n = 0; n < 200; n++) begin
        logic             rv;
        logic [VC_ID_W-1:0] rid;
        logic [63:0]      rd;
        logic [2:0]       rr;
        logic [1:0]       rq;
        int               sel;
        rv  = ($urandom_range(0, 3) != 0);
        rid = ($urandom_range(0, 19) == 0) ? VC_ID_W'($urandom_range(2, 3))
                                           : VC_ID_W'($urandom_range(0, 1));
        rd  = {$urandom, $urandom};
        rr  = 3'($urandom_range(0, 7));
        sel = $urandom_range(0, 9);
        rq  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
        cycle(rv, rid, rd, rr, rq, 1'b0, none);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
